// File: rtl/demo_recorder.sv
// Samples live synth channel state at a fixed step rate and streams packed step words to a song RAM.
// A take runs until rec_stop or until the RAM is full; reset aborts it.
module demo_recorder #(
    parameter int unsigned NUM_CHANNELS = 25,
    parameter int unsigned SONG_LENGTH  = 1536,
    parameter int unsigned CLK_DIVIDE   = 149999,
    parameter int unsigned ADDR_SIZE    = $clog2(SONG_LENGTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CHANNELS-1:0]   channel_ena,
    input  logic [2*NUM_CHANNELS-1:0] waveforms,
    input  logic [12*NUM_CHANNELS-1:0] pitches,
    input  logic                      rec_start,
    input  logic                      rec_stop,
    output logic                      wr_en,
    output logic [ADDR_SIZE-1:0]      wr_addr,
    output logic [95:0]               wr_data,
    output logic [ADDR_SIZE:0]        rec_length,
    output logic                      recording,
    output logic                      done,
    output logic                      overflow
);

    localparam int unsigned DivW     = (CLK_DIVIDE > 0) ? $clog2(CLK_DIVIDE + 1) : 1;
    localparam int unsigned NumSlots = 6;
    localparam logic [ADDR_SIZE-1:0] LastAddr  = ADDR_SIZE'(SONG_LENGTH - 1);
    localparam logic [DivW-1:0]      DivReload = DivW'(CLK_DIVIDE);

    typedef enum logic [1:0] {StIdle, StRecord, StDone} state_e;

    state_e                 state_q, state_d;
    logic [DivW-1:0]        div_q, div_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE:0]     len_q, len_d;
    logic                   ovf_q, ovf_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [95:0]            wr_data_q, wr_data_d;

    logic                   tick;
    logic [95:0]            step_word;
    logic                   step_ovf;
    logic [2:0]             slot;

    assign tick = (div_q == '0);

    // Enabled channels claim slots in ascending index order; the rest are dropped.
    always_comb begin
        step_word = '0;
        step_ovf  = 1'b0;
        slot      = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (channel_ena[k]) begin
                if (slot < 3'(NumSlots)) begin
                    step_word[{slot, 4'b0000} +: 16] =
                        {1'b1, waveforms[2*k +: 2], 1'b0, pitches[12*k +: 12]};
                    slot = slot + 3'd1;
                end else begin
                    step_ovf = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        addr_d    = addr_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (rec_start && !rec_stop) begin
                    state_d = StRecord;
                    addr_d  = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    div_d   = '0;
                end
            end
            StRecord: begin
                div_d = tick ? DivReload : div_q - 1'b1;
                if (tick) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = step_word;
                    addr_d    = addr_q + 1'b1;
                    len_d     = {1'b0, addr_q} + 1'b1;
                    if (step_ovf) begin
                        ovf_d = 1'b1;
                    end
                    if (addr_q == LastAddr) begin
                        state_d = StDone;
                    end
                end
                if (rec_stop) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rec_length = len_q;
    assign overflow   = ovf_q;
    assign recording  = (state_q == StRecord);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_demo_recorder.sv
// Bench for demo_recorder: packing vector table, directed takes, randomized takes against a
// trace-level model, and an asynchronous reset abort.
module tb_demo_recorder;

    localparam int NCH = 8;
    localparam int SL  = 4;
    localparam int CD  = 3;
    localparam int AW  = $clog2(SL);

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  channel_ena;
    logic [2*NCH-1:0] waveforms;
    logic [12*NCH-1:0] pitches;
    logic            rec_start;
    logic            rec_stop;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [95:0]     wr_data;
    logic [AW:0]     rec_length;
    logic            recording;
    logic            done;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    demo_recorder #(
        .NUM_CHANNELS(NCH),
        .SONG_LENGTH (SL),
        .CLK_DIVIDE  (CD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .channel_ena(channel_ena),
        .waveforms  (waveforms),
        .pitches    (pitches),
        .rec_start  (rec_start),
        .rec_stop   (rec_stop),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rec_length (rec_length),
        .recording  (recording),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ena;
        logic [15:0] wf;
        logic [95:0] pit;
        logic [95:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step word from the slot rules: gather enabled channels in order, keep the first six.
    // Bit 96 flags that some enabled channel was dropped.
    function automatic logic [96:0] model_pack(input logic [7:0] ena, input logic [15:0] wf,
                                               input logic [95:0] pit);
        logic [15:0] q[$];
        logic [95:0] d;
        d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ena[k]) q.push_back({1'b1, wf[2*k +: 2], 1'b0, pit[12*k +: 12]});
        end
        for (int s = 0; s < 6 && s < q.size(); s++) d[16*s +: 16] = q[s];
        return {q.size() > 6, d};
    endfunction

    // One take from IDLE/DONE: start at relative cycle 0, optional stop at stop_at (>=1).
    task automatic run_take(input int stop_at, input bit fixed_inputs);
        int last_tick;
        int done_cyc;
        int nwrites;
        bit ovf;
        bit is_tick;
        logic [96:0] exp;
        last_tick = 1 + (SL - 1) * (CD + 1);
        done_cyc  = (stop_at < last_tick) ? stop_at : last_tick;
        nwrites   = 0;
        ovf       = 1'b0;
        for (int i = 0; i <= done_cyc + 2; i++) begin
            if (!fixed_inputs) begin
                channel_ena = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                waveforms   = 16'($urandom);
                pitches     = {$urandom, $urandom, $urandom};
            end
            rec_start = (i == 0) || (i >= 1 && i <= done_cyc && $urandom_range(0, 3) == 0);
            rec_stop  = (i == stop_at);
            is_tick   = (i >= 1) && (i <= done_cyc) && ((i - 1) % (CD + 1) == 0);
            exp       = model_pack(channel_ena, waveforms, pitches);
            step();
            chk("take_wr_en", 96'(wr_en), 96'(is_tick));
            if (is_tick) begin
                chk("take_wr_addr", 96'(wr_addr), 96'(nwrites));
                chk("take_wr_data", wr_data, exp[95:0]);
                nwrites++;
                if (exp[96]) ovf = 1'b1;
            end
            chk("take_recording", 96'(recording), 96'(i + 1 <= done_cyc));
            chk("take_done", 96'(done), 96'(i + 1 > done_cyc));
        end
        rec_start = 1'b0;
        rec_stop  = 1'b0;
        chk("take_rec_length", 96'(rec_length), 96'(nwrites));
        chk("take_overflow", 96'(overflow), 96'(ovf));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h09, 16'h5555, 96'h000_000_000_000_06A_000_000_0D4,
                    96'h0000_0000_0000_0000_A06A_A0D4, 1'b0};
        vecs[1] = '{8'hFF, 16'hFFFF, 96'h123_123_123_123_123_123_123_123,
                    96'hE123_E123_E123_E123_E123_E123, 1'b1};
        vecs[2] = '{8'h00, 16'hFFFF, 96'hFFF_FFF_FFF_FFF_FFF_FFF_FFF_FFF, 96'h0, 1'b0};
        vecs[3] = '{8'h80, 16'h8000, 96'hFFF_000_000_000_000_000_000_000,
                    96'h0000_0000_0000_0000_0000_CFFF, 1'b0};
        vecs[4] = '{8'hFC, 16'h0000, 96'h007_006_005_004_003_002_000_000,
                    96'h8007_8006_8005_8004_8003_8002, 1'b0};
        vecs[5] = '{8'h7F, 16'h5555, 96'h070_060_050_040_030_020_010_000,
                    96'hA050_A040_A030_A020_A010_A000, 1'b1};

        rst = 1'b1;
        channel_ena = '0;
        waveforms = '0;
        pitches = '0;
        rec_start = 1'b0;
        rec_stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 96'(wr_en), 96'(0));
        chk("rst_wr_addr", 96'(wr_addr), 96'(0));
        chk("rst_wr_data", wr_data, 96'(0));
        chk("rst_rec_length", 96'(rec_length), 96'(0));
        chk("rst_recording", 96'(recording), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_overflow", 96'(overflow), 96'(0));
        rst = 1'b0;

        // Start and stop together in IDLE: nothing happens.
        channel_ena = 8'hFF;
        rec_start = 1'b1;
        rec_stop = 1'b1;
        step();
        rec_start = 1'b0;
        rec_stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("both_idle_wr_en", 96'(wr_en), 96'(0));
            chk("both_idle_recording", 96'(recording), 96'(0));
            chk("both_idle_done", 96'(done), 96'(0));
            step();
        end

        // Packing table: one-write takes ended by stop on the first tick.
        for (int v = 0; v < 6; v++) begin
            channel_ena = vecs[v].ena;
            waveforms   = vecs[v].wf;
            pitches     = vecs[v].pit;
            rec_start   = 1'b1;
            step();
            rec_start = 1'b0;
            chk("vec_start_recording", 96'(recording), 96'(1));
            chk("vec_start_overflow_clr", 96'(overflow), 96'(0));
            chk("vec_start_len_clr", 96'(rec_length), 96'(0));
            chk("vec_start_wr_en", 96'(wr_en), 96'(0));
            rec_stop = 1'b1;
            step();
            rec_stop = 1'b0;
            chk("vec_wr_en", 96'(wr_en), 96'(1));
            chk("vec_wr_addr", 96'(wr_addr), 96'(0));
            chk("vec_wr_data", wr_data, vecs[v].exp_data);
            chk("vec_overflow", 96'(overflow), 96'(vecs[v].exp_ovf));
            chk("vec_done", 96'(done), 96'(1));
            chk("vec_rec_length", 96'(rec_length), 96'(1));
            channel_ena = '0;
            repeat (3) step();
            chk("vec_hold_wr_en", 96'(wr_en), 96'(0));
            chk("vec_hold_wr_data", wr_data, vecs[v].exp_data);
            chk("vec_sticky_overflow", 96'(overflow), 96'(vecs[v].exp_ovf));
            chk("vec_hold_len", 96'(rec_length), 96'(1));
        end

        // Start and stop together in DONE: stays DONE.
        rec_start = 1'b1;
        rec_stop = 1'b1;
        step();
        rec_start = 1'b0;
        rec_stop = 1'b0;
        chk("both_done_done", 96'(done), 96'(1));
        chk("both_done_recording", 96'(recording), 96'(0));

        // Full take to RAM end with fixed inputs, then stop on the second tick.
        channel_ena = 8'h09;
        waveforms   = 16'h5555;
        pitches     = 96'h000_000_000_000_06A_000_000_0D4;
        run_take(99, 1'b1);
        chk("full_take_data", wr_data, 96'h0000_0000_0000_0000_A06A_A0D4);
        repeat (4) begin
            step();
            chk("full_take_no_fifth", 96'(wr_en), 96'(0));
        end
        run_take(1 + (CD + 1), 1'b1);

        for (int n = 0; n < 20; n++) begin
            run_take($urandom_range(1, 16), 1'b0);
        end

        // Asynchronous reset between edges, while a write strobe is visible.
        channel_ena = 8'h01;
        rec_start = 1'b1;
        step();
        rec_start = 1'b0;
        step();
        chk("abort_pre_wr_en", 96'(wr_en), 96'(1));
        #3 rst = 1'b1;
        #1;
        chk("abort_wr_en", 96'(wr_en), 96'(0));
        chk("abort_recording", 96'(recording), 96'(0));
        chk("abort_rec_length", 96'(rec_length), 96'(0));
        chk("abort_wr_addr", 96'(wr_addr), 96'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_no_write", 96'(wr_en), 96'(0));
            chk("abort_no_resume", 96'(recording), 96'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
